// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the next-PC select / decode path.
//
// Owns the architectural fetch PC, issues reads to a 1-cycle-latency
// instruction BRAM, and buffers returned words in a 2-entry skid queue that
// is presented to decode over a valid/ready handshake.
//
// Ports:
//   clk, rst        core clock; synchronous active-high reset
//   redirect_valid  apply pcnext this cycle (flushes all younger fetches)
//   pcnext          redirect target byte address, bits [1:0] ignored
//   imem_en         BRAM read enable (one read per asserted cycle)
//   imem_addr       BRAM byte address, always equal to the fetch PC
//   imem_rdata      BRAM read data, valid the cycle after imem_en
//   out_valid       head entry valid toward decode
//   out_ready       decode accepts the head entry this cycle
//   out_pc          PC of the head instruction
//   out_pc4         out_pc + 4 (mod 2^32)
//   out_instr       head instruction word
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] pcnext,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic [31:0] out_instr
);

  logic [31:0] pc_q;
  logic        inflight;
  logic [31:0] inflight_pc;

  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ;

  // pcnext[1:0] is deliberately dropped: targets are forced word-aligned.
  logic        unused_pcnext_lsb;
  assign unused_pcnext_lsb = ^pcnext[1:0];

  always_comb begin
    out_valid = !rst && (count != 2'd0);
    pop       = out_valid && out_ready;
    // Slots that will be committed after this cycle: entries kept plus the
    // read already in flight. A new read may only go out if one slot remains.
    occ       = {1'b0, count} - {2'b00, pop} + {2'b00, inflight};
    issue     = !rst && !redirect_valid && (occ <= 3'd1);
    push      = inflight && !redirect_valid;
    // Tail index is head + count mod 2; with count in 0..2 that is an xor.
    wr_ptr    = rd_ptr ^ count[0];
  end

  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign out_pc    = q_pc[rd_ptr];
  assign out_instr = q_instr[rd_ptr];
  assign out_pc4   = q_pc[rd_ptr] + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
    end else if (redirect_valid) begin
      // A simultaneous pop is already consumed by decode; the flush
      // discards whatever remains, including the returning read.
      pc_q     <= {pcnext[31:2], 2'b00};
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
    end else begin
      if (issue) begin
        pc_q        <= pc_q + 32'd4;
        inflight_pc <= pc_q;
      end
      inflight <= issue;
      if (push) begin
        q_pc[wr_ptr]    <= inflight_pc;
        q_instr[wr_ptr] <= imem_rdata;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifndef SYNTHESIS
  // The issue throttle must make overflow impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == 2'd2))
    else $error("fetch_unit: skid queue overflow");
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        redirect_valid;
  logic [31:0] pcnext;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_pc4, out_instr;

  logic        redir1;
  logic [31:0] pcnext1;
  logic        imem_en1;
  logic [31:0] imem_addr1;
  logic [31:0] imem_rdata1;
  logic        out_valid1;
  logic        rdy1;
  logic [31:0] out_pc1, out_pc41, out_instr1;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u0 (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .pcnext(pcnext),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc4(out_pc4), .out_instr(out_instr)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk(clk), .rst(rst), .redirect_valid(redir1), .pcnext(pcnext1),
    .imem_en(imem_en1), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
    .out_valid(out_valid1), .out_ready(rdy1),
    .out_pc(out_pc1), .out_pc4(out_pc41), .out_instr(out_instr1)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) if (imem_en)  imem_rdata  <= word_at(imem_addr);
  always @(posedge clk) if (imem_en1) imem_rdata1 <= word_at(imem_addr1);

  int vectors = 0;
  int miscompares = 0;
  int pops0 = 0;
  int pops1 = 0;
  logic [31:0] expq[$];
  logic [31:0] expq1[$];

  task automatic load_exp0(input logic [31:0] start);
    expq.delete();
    for (int i = 0; i < 64; i++) expq.push_back(start + 32'(4 * i));
  endtask

  task automatic load_exp1(input logic [31:0] start);
    expq1.delete();
    for (int i = 0; i < 64; i++) expq1.push_back(start + 32'(4 * i));
  endtask

  // Scoreboard: compares every accepted head entry against the expected
  // stream, then advances one clock. Called with inputs already settled.
  task automatic clock_edge();
    logic [31:0] e;
    if (out_valid && out_ready) begin
      pops0++;
      if (expq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL u0_unexpected: got pc %h, required no output", out_pc);
      end else begin
        e = expq.pop_front();
        vectors += 3;
        if (out_pc !== e) begin miscompares++;
          $display("FAIL u0_pc: got %h required %h", out_pc, e); end
        if (out_pc4 !== e + 32'd4) begin miscompares++;
          $display("FAIL u0_pc4: got %h required %h", out_pc4, e + 32'd4); end
        if (out_instr !== word_at(e)) begin miscompares++;
          $display("FAIL u0_instr: got %h required %h", out_instr, word_at(e)); end
      end
    end
    if (out_valid1 && rdy1) begin
      pops1++;
      if (expq1.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL u1_unexpected: got pc %h, required no output", out_pc1);
      end else begin
        e = expq1.pop_front();
        vectors += 3;
        if (out_pc1 !== e) begin miscompares++;
          $display("FAIL u1_pc: got %h required %h", out_pc1, e); end
        if (out_pc41 !== e + 32'd4) begin miscompares++;
          $display("FAIL u1_pc4: got %h required %h", out_pc41, e + 32'd4); end
        if (out_instr1 !== word_at(e)) begin miscompares++;
          $display("FAIL u1_instr: got %h required %h", out_instr1, word_at(e)); end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    expq.delete(); expq1.delete();
    #1;
    vectors += 3;
    if (imem_en !== 1'b0) begin miscompares++;
      $display("FAIL reset_en: got %b required 0", imem_en); end
    if (out_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_valid: got %b required 0", out_valid); end
    if (out_valid1 !== 1'b0) begin miscompares++;
      $display("FAIL reset_valid1: got %b required 0", out_valid1); end
    clock_edge();
    clock_edge();
    rst = 1'b0;
    load_exp0(32'h0);
    load_exp1(32'hFFFF_FFF8);
    #1;
    vectors += 2;
    if (imem_en !== 1'b1) begin miscompares++;
      $display("FAIL first_issue_en: got %b required 1", imem_en); end
    if (imem_addr !== 32'h0) begin miscompares++;
      $display("FAIL first_issue_addr: got %h required 0", imem_addr); end
    clock_edge();
    #1;
    vectors += 2;
    if (out_valid !== 1'b0) begin miscompares++;
      $display("FAIL latency_valid_early: got %b required 0", out_valid); end
    if (imem_addr !== 32'h4) begin miscompares++;
      $display("FAIL second_addr: got %h required 4", imem_addr); end
    clock_edge();
    for (int k = 0; k < 6; k++) begin
      #1;
      vectors += 3;
      if (imem_en !== 1'b1) begin miscompares++;
        $display("FAIL stream_en: got %b required 1", imem_en); end
      if (imem_addr !== 32'(8 + 4 * k)) begin miscompares++;
        $display("FAIL stream_addr: got %h required %h", imem_addr, 32'(8 + 4 * k)); end
      if (out_valid !== 1'b1) begin miscompares++;
        $display("FAIL stream_valid: got %b required 1", out_valid); end
      clock_edge();
    end
  endtask

  task automatic test_stall();
    rst = 1'b1; out_ready = 1'b0;
    expq.delete();
    #1;
    clock_edge();
    rst = 1'b0;
    load_exp0(32'h0);
    #1;
    vectors += 2;
    if (imem_en !== 1'b1) begin miscompares++;
      $display("FAIL stall_t0_en: got %b required 1", imem_en); end
    if (imem_addr !== 32'h0) begin miscompares++;
      $display("FAIL stall_t0_addr: got %h required 0", imem_addr); end
    clock_edge();
    #1;
    vectors += 2;
    if (imem_en !== 1'b1) begin miscompares++;
      $display("FAIL stall_t1_en: got %b required 1", imem_en); end
    if (out_valid !== 1'b0) begin miscompares++;
      $display("FAIL stall_t1_valid: got %b required 0", out_valid); end
    clock_edge();
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors += 4;
      if (out_valid !== 1'b1) begin miscompares++;
        $display("FAIL stall_hold_valid: got %b required 1", out_valid); end
      if (out_pc !== 32'h0) begin miscompares++;
        $display("FAIL stall_hold_pc: got %h required 0", out_pc); end
      if (imem_en !== 1'b0) begin miscompares++;
        $display("FAIL stall_hold_en: got %b required 0", imem_en); end
      if (imem_addr !== 32'h8) begin miscompares++;
        $display("FAIL stall_hold_addr: got %h required 8", imem_addr); end
      clock_edge();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++;
        $display("FAIL stall_release_gap: got %b required 1", out_valid); end
      clock_edge();
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin #1; clock_edge(); end
    redirect_valid = 1'b1; pcnext = 32'h0000_0102;
    #1;
    vectors++;
    if (imem_en !== 1'b0) begin miscompares++;
      $display("FAIL redir_en: got %b required 0", imem_en); end
    clock_edge();
    load_exp0(32'h100);
    redirect_valid = 1'b0; out_ready = 1'b1;
    #1;
    vectors += 3;
    if (out_valid !== 1'b0) begin miscompares++;
      $display("FAIL redir_flush_valid: got %b required 0", out_valid); end
    if (imem_en !== 1'b1) begin miscompares++;
      $display("FAIL redir_t1_en: got %b required 1", imem_en); end
    if (imem_addr !== 32'h100) begin miscompares++;
      $display("FAIL redir_t1_addr: got %h required 100", imem_addr); end
    clock_edge();
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++;
      $display("FAIL redir_t2_valid: got %b required 0", out_valid); end
    clock_edge();
    #1;
    vectors += 2;
    if (out_valid !== 1'b1) begin miscompares++;
      $display("FAIL redir_t3_valid: got %b required 1", out_valid); end
    if (out_pc !== 32'h100) begin miscompares++;
      $display("FAIL redir_t3_pc: got %h required 100", out_pc); end
    clock_edge();
    for (int k = 0; k < 3; k++) begin #1; clock_edge(); end
  endtask

  task automatic test_back_to_back();
    int start_pops;
    #1;
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++;
      $display("FAIL b2b_pre_valid: got %b required 1", out_valid); end
    redirect_valid = 1'b1; pcnext = 32'h200;
    #1;
    vectors++;
    if (imem_en !== 1'b0) begin miscompares++;
      $display("FAIL b2b_first_en: got %b required 0", imem_en); end
    clock_edge();
    load_exp0(32'h200);
    pcnext = 32'h300;
    #1;
    vectors += 2;
    if (imem_en !== 1'b0) begin miscompares++;
      $display("FAIL b2b_second_en: got %b required 0", imem_en); end
    if (out_valid !== 1'b0) begin miscompares++;
      $display("FAIL b2b_second_valid: got %b required 0", out_valid); end
    clock_edge();
    load_exp0(32'h300);
    redirect_valid = 1'b0;
    #1;
    vectors += 2;
    if (imem_en !== 1'b1) begin miscompares++;
      $display("FAIL b2b_issue_en: got %b required 1", imem_en); end
    if (imem_addr !== 32'h300) begin miscompares++;
      $display("FAIL b2b_issue_addr: got %h required 300", imem_addr); end
    start_pops = pops0;
    clock_edge();
    for (int k = 0; k < 7; k++) begin #1; clock_edge(); end
    vectors++;
    if (pops0 - start_pops !== 6) begin miscompares++;
      $display("FAIL b2b_throughput: got %0d deliveries required 6", pops0 - start_pops); end
  endtask

  task automatic test_wrap();
    int start_pops;
    rst = 1'b1; rdy1 = 1'b1; out_ready = 1'b1;
    expq.delete(); expq1.delete();
    #1;
    clock_edge();
    rst = 1'b0;
    load_exp0(32'h0);
    load_exp1(32'hFFFF_FFF8);
    start_pops = pops1;
    for (int k = 0; k < 6; k++) begin #1; clock_edge(); end
    vectors++;
    if (pops1 - start_pops !== 4) begin miscompares++;
      $display("FAIL wrap_deliveries: got %0d required 4", pops1 - start_pops); end
    rdy1 = 1'b0;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin #1; clock_edge(); end
    rst = 1'b1;
    expq.delete();
    #1;
    vectors += 2;
    if (imem_en !== 1'b0) begin miscompares++;
      $display("FAIL midrst_en: got %b required 0", imem_en); end
    if (out_valid !== 1'b0) begin miscompares++;
      $display("FAIL midrst_valid: got %b required 0", out_valid); end
    clock_edge();
    rst = 1'b0;
    load_exp0(32'h0);
    #1;
    vectors += 3;
    if (imem_en !== 1'b1) begin miscompares++;
      $display("FAIL midrst_restart_en: got %b required 1", imem_en); end
    if (imem_addr !== 32'h0) begin miscompares++;
      $display("FAIL midrst_restart_addr: got %h required 0", imem_addr); end
    if (out_valid !== 1'b0) begin miscompares++;
      $display("FAIL midrst_stale_t0: got %b required 0", out_valid); end
    clock_edge();
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++;
      $display("FAIL midrst_stale_t1: got %b required 0", out_valid); end
    clock_edge();
    #1;
    vectors += 3;
    if (out_valid !== 1'b1) begin miscompares++;
      $display("FAIL midrst_valid_t2: got %b required 1", out_valid); end
    if (out_pc !== 32'h0) begin miscompares++;
      $display("FAIL midrst_pc: got %h required 0", out_pc); end
    if (out_instr !== 32'h1000_0000) begin miscompares++;
      $display("FAIL midrst_instr: got %h required 10000000", out_instr); end
    clock_edge();
    for (int k = 0; k < 4; k++) begin #1; clock_edge(); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; pcnext = 32'h0; out_ready = 1'b0;
    redir1 = 1'b0; pcnext1 = 32'h0; rdy1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
